alu_mdu: RTL and testbench
==========================

// Module: alu_mdu
// PURPOSE
//  Parametrised multi-cycle multiply/divide unit with HI/LO registers, beside the combinational ALU in EX.
//  Executes MULT/MULTU/DIV/DIVU iteratively (one bit per cycle), plus MTHI/MTLO.
//  Reports busy/done so the hazard unit can stall MFHI/MFLO and later mul/div ops.
// PARAMETERS
//  WIDTH   32   operand/HI/LO width; even, >= 8
//  CNT_W   $clog2(WIDTH)+1   iteration counter width (derived, localparam)
// PORTS
//  clk     in   1      rising-edge clock
//  rst     in   1      synchronous active-high reset
//  start   in   1      request; sampled with op/src1/src2
//  op      in   6      funct code: MULT 011000, MULTU 011001, DIV 011010, DIVU 011011, MTHI 010001, MTLO 010011
//  src1    in   WIDTH  rs operand (multiplicand / dividend / MTHI/MTLO data)
//  src2    in   WIDTH  rt operand (multiplier / divisor)
//  cancel  in   1      pipeline flush; aborts any in-flight operation
//  busy    out  1      mul/div in progress
//  done    out  1      one-cycle pulse when HI/LO take a mul/div result
//  hi      out  WIDTH  HI register (MFHI source)
//  lo      out  WIDTH  LO register (MFLO source)
// BEHAVIOUR
//  - Reset: state IDLE, busy=0, done=0, hi=0, lo=0, counter=0. Reset mid-operation discards it; no done.
//  - States: IDLE, RUN. Accept when start=1 & busy=0 & cancel=0 at an edge; else start ignored (no queue).
//  - Mul/div accept: IDLE->RUN, operands latched (signed ops latch magnitudes + result signs), counter=WIDTH.
//  - RUN: one shift-add (mul) or restoring shift-subtract (div) step per cycle; counter decrements.
//  - Final step (counter=1): hi/lo written, RUN->IDLE, busy=0, done=1 next cycle only.
//  - Latency: done and new hi/lo visible exactly WIDTH edges after the accepting edge; busy high for those WIDTH cycles.
//  - Back-to-back: new start accepted in the cycle done=1.
//  - MTHI/MTLO in IDLE: hi (or lo) <= src1 at the accepting edge; busy stays 0, done stays 0. Unknown op: ignored.
//  - Mul: {hi,lo} = 2*WIDTH-bit product; MULT signed two's complement, MULTU unsigned.
//  - Div: lo=quotient, hi=remainder. DIV truncates toward zero; remainder takes dividend's sign.
//  - DIV MIN / -1: lo=MIN, hi=0 (wraps, no trap).
//  - Divide by zero (DIV or DIVU): hi=src1, lo=all ones; full WIDTH-cycle latency.
//  - cancel in RUN: RUN->IDLE next edge, hi/lo unchanged, no done. cancel with start in IDLE: start dropped.
//  - hi/lo change only at a mul/div completion, MTHI/MTLO, or reset.
// CONFIGURATION
//  MDU_FAST_MUL_EN defined: MULT/MULTU take 1 cycle (registered full product); done pulses the cycle after acceptance,
//    busy high for that 1 cycle; DIV/DIVU unchanged (WIDTH cycles).
//  MDU_FAST_MUL_EN undefined: all mul/div ops iterative, WIDTH cycles.
// TESTING (WIDTH=32, macro undefined unless stated)
//  1. MULT 0xFFFFFFFD * 0x00000007 -> done 32 edges after accept; hi=0xFFFFFFFF lo=0xFFFFFFEB; busy high 32 cycles.
//  2. MULTU 0xFFFFFFFF * 0xFFFFFFFF -> hi=0xFFFFFFFE lo=0x00000001; with MDU_FAST_MUL_EN done after 1 edge, same values.
//  3. DIV 0xFFFFFFF9 / 2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000 hi=0.
//  4. DIVU 7 / 0 -> hi=0x00000007 lo=0xFFFFFFFF after 32 cycles, done pulses once.
//  5. MTHI 0x1234 preloaded; start DIVU 100/7, cancel at cycle 10 -> no done, hi=0x1234, busy=0 next cycle; restart -> lo=14 hi=2.
//  6. start MULTU while busy -> ignored, first result intact; rst at cycle 5 -> busy=0 done=0 hi=lo=0, no later done.

Source files
------------

// File: rtl/alu_mdu.sv
// alu_mdu: iterative multiply/divide unit with HI/LO registers.
//  MULT/MULTU use one shift-add step per cycle, DIV/DIVU one restoring
//  shift-subtract step per cycle; signed ops run on magnitudes and fix
//  the result signs on the final step. MTHI/MTLO write HI/LO directly.
//  Optional macro MDU_FAST_MUL_EN: MULT/MULTU complete in a single cycle
//  from a registered full-width product; DIV/DIVU stay iterative.
module alu_mdu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [5:0]       op,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  localparam logic [5:0] OP_MULT  = 6'b011000;
  localparam logic [5:0] OP_MULTU = 6'b011001;
  localparam logic [5:0] OP_DIV   = 6'b011010;
  localparam logic [5:0] OP_DIVU  = 6'b011011;
  localparam logic [5:0] OP_MTHI  = 6'b010001;
  localparam logic [5:0] OP_MTLO  = 6'b010011;

`ifdef MDU_FAST_MUL_EN
  localparam int MUL_CYC = 1;
`else
  localparam int MUL_CYC = WIDTH;
`endif

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0] cnt_q;
  logic             done_q;
  logic [WIDTH-1:0] hi_q, lo_q;

  // operand / partial-result registers (data only, no reset)
  logic [WIDTH-1:0] a_q;      // multiplicand or divisor magnitude
  logic [WIDTH-1:0] p_hi_q;   // product upper half / partial remainder
  logic [WIDTH-1:0] p_lo_q;   // multiplier shifter / dividend-quotient shifter
  logic             is_div_q;
  logic             neg_q;    // negate product or quotient at the end
  logic             rneg_q;   // negate remainder at the end
  logic             div0_q;   // divisor was zero

  logic step_en, finish, last;

  // conditional two's-complement negate, operand width
  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v,
                                                input logic n);
    return n ? -v : v;
  endfunction

  // conditional two's-complement negate, double width
  function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] v,
                                                   input logic n);
    return n ? -v : v;
  endfunction

  // ---------------- request decode ----------------
  logic is_mul_op, is_div_op, signed_op;
  logic accept, acc_muldiv, acc_mthi, acc_mtlo;
  logic sgn_a, sgn_b;
  logic [WIDTH-1:0] mag_a, mag_b;

  assign is_mul_op  = (op == OP_MULT) || (op == OP_MULTU);
  assign is_div_op  = (op == OP_DIV)  || (op == OP_DIVU);
  assign signed_op  = (op == OP_MULT) || (op == OP_DIV);
  assign accept     = start && !busy && !cancel;
  assign acc_muldiv = accept && (is_mul_op || is_div_op);
  assign acc_mthi   = accept && (op == OP_MTHI);
  assign acc_mtlo   = accept && (op == OP_MTLO);

  assign sgn_a = signed_op && src1[WIDTH-1];
  assign sgn_b = signed_op && src2[WIDTH-1];
  assign mag_a = cond_neg(src1, sgn_a);
  assign mag_b = cond_neg(src2, sgn_b);

  assign last = (cnt_q == CNT_W'(1));

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (acc_muldiv) state_d = S_RUN;
      S_RUN:  if (cancel || last) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: busy, per-cycle step enable, completion strobe
  always_comb begin
    busy    = 1'b0;
    step_en = 1'b0;
    finish  = 1'b0;
    if (state_q == S_RUN) begin
      busy    = 1'b1;
      step_en = !cancel;
      finish  = !cancel && last;
    end
  end

  // ---------------- iteration step ----------------
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_n, mul_lo_n;
  logic [WIDTH:0]   div_sh, div_diff;
  logic             div_ok;
  logic [WIDTH-1:0] div_hi_n, div_lo_n;
  logic [WIDTH-1:0] step_hi, step_lo;

  assign mul_sum  = {1'b0, p_hi_q} + (p_lo_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
  assign mul_hi_n = mul_sum[WIDTH:1];
  assign mul_lo_n = {mul_sum[0], p_lo_q[WIDTH-1:1]};

  // restoring divide: remainder < divisor, so WIDTH+1 bits hold the trial difference
  assign div_sh   = {p_hi_q, p_lo_q[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, a_q};
  assign div_ok   = !div_diff[WIDTH];
  assign div_hi_n = div_ok ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
  assign div_lo_n = {p_lo_q[WIDTH-2:0], div_ok};

  assign step_hi = is_div_q ? div_hi_n : mul_hi_n;
  assign step_lo = is_div_q ? div_lo_n : mul_lo_n;

  // ---------------- final result ----------------
  logic [2*WIDTH-1:0] prod_mag, prod_res;
  logic [WIDTH-1:0]   quo_res, rem_res, res_hi, res_lo;

`ifdef MDU_FAST_MUL_EN
  assign prod_mag = {p_hi_q, p_lo_q};
`else
  assign prod_mag = {mul_hi_n, mul_lo_n};
`endif
  assign prod_res = cond_neg2(prod_mag, neg_q);
  // divide by zero: quotient all ones, remainder equals the dividend
  assign quo_res  = div0_q ? {WIDTH{1'b1}} : cond_neg(div_lo_n, neg_q);
  assign rem_res  = cond_neg(div_hi_n, rneg_q);
  assign res_hi   = is_div_q ? rem_res : prod_res[2*WIDTH-1:WIDTH];
  assign res_lo   = is_div_q ? quo_res : prod_res[WIDTH-1:0];

  // iteration counter: loaded on accept, counts down each step, cleared on cancel
  always_ff @(posedge clk) begin
    if (rst)             cnt_q <= '0;
    else if (acc_muldiv) cnt_q <= is_div_op ? CNT_W'(WIDTH) : CNT_W'(MUL_CYC);
    else if (step_en)    cnt_q <= cnt_q - CNT_W'(1);
    else if (busy)       cnt_q <= '0;
  end

  // operand latch on accept, then one shift step per running cycle
  always_ff @(posedge clk) begin
    if (acc_muldiv) begin
      is_div_q <= is_div_op;
      neg_q    <= sgn_a ^ sgn_b;
      if (is_div_op) begin
        a_q    <= mag_b;
        p_hi_q <= '0;
        p_lo_q <= mag_a;
        rneg_q <= sgn_a;
        div0_q <= (src2 == '0);
      end else begin
        a_q    <= mag_a;
        rneg_q <= 1'b0;
        div0_q <= 1'b0;
`ifdef MDU_FAST_MUL_EN
        {p_hi_q, p_lo_q} <= {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
`else
        p_hi_q <= '0;
        p_lo_q <= mag_b;
`endif
      end
    end else if (step_en) begin
      p_hi_q <= step_hi;
      p_lo_q <= step_lo;
    end
  end

  // completion pulse, one cycle after the final step
  always_ff @(posedge clk) begin
    if (rst) done_q <= 1'b0;
    else     done_q <= finish;
  end

  // architectural HI/LO: written by completion or MTHI/MTLO only
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (finish) begin
      hi_q <= res_hi;
      lo_q <= res_lo;
    end else begin
      if (acc_mthi) hi_q <= src1;
      if (acc_mtlo) lo_q <= src1;
    end
  end

  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: directed scoreboard bench for alu_mdu (WIDTH=32).
module tb_alu_mdu;
  localparam int W = 32;
`ifdef MDU_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = W;
`endif

  localparam logic [5:0] OP_MULT  = 6'b011000;
  localparam logic [5:0] OP_MULTU = 6'b011001;
  localparam logic [5:0] OP_DIV   = 6'b011010;
  localparam logic [5:0] OP_DIVU  = 6'b011011;
  localparam logic [5:0] OP_MTHI  = 6'b010001;
  localparam logic [5:0] OP_MTLO  = 6'b010011;

  logic         clk = 1'b0;
  logic         rst, start, cancel;
  logic [5:0]   op;
  logic [W-1:0] src1, src2;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  alu_mdu #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src1(src1), .src2(src2),
    .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           t;
    string        name;
  } exp_t;

  exp_t sb[$];
  int tests = 0;
  int fails = 0;

  // monitor: every done pulse pops one expected result
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_done: done=1 at cycle %0d, required no done", cyc);
      end else begin
        e = sb.pop_front();
        if (hi !== e.hi || lo !== e.lo || cyc != e.t) begin
          fails++;
          $display("FAIL %s: hi=%h lo=%h cycle=%0d, required hi=%h lo=%h cycle=%0d",
                   e.name, hi, lo, cyc, e.hi, e.lo, e.t);
        end
      end
    end
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // issue one mul/div at the current negedge and wait (bounded) for done;
  // inj>0 drives a MULTU request while busy on that cycle, which must be ignored
  task automatic run_op(input string name, input logic [5:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] eh,
                        input logic [W-1:0] el, input int lat, input int inj);
    int n, bcnt;
    bit got;
    op = o; src1 = a; src2 = b; start = 1'b1;
    sb.push_back('{eh, el, cyc + 1 + lat, name});
    n = 0; bcnt = 0; got = 1'b0;
    while (!got && n < 100) begin
      @(negedge clk);
      start = 1'b0;
      n++;
      if (n == inj) begin
        start = 1'b1; op = OP_MULTU; src1 = '1; src2 = '1;
      end
      if (busy) bcnt++;
      if (done) got = 1'b1;
    end
    tests++;
    if (!got) begin
      fails++;
      $display("FAIL %s_timeout: no done within %0d cycles, required done", name, n);
    end else if (bcnt != lat) begin
      fails++;
      $display("FAIL %s_busy: busy cycles %0d, required %0d", name, bcnt, lat);
    end
  endtask

  initial begin
    bit saw;
    rst = 1'b1; start = 1'b0; cancel = 1'b0; op = '0; src1 = '0; src2 = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    rst = 1'b0;
    @(negedge clk);

    run_op("mult_neg",   OP_MULT,  32'hFFFFFFFD, 32'h7,        32'hFFFFFFFF, 32'hFFFFFFEB, MUL_LAT, 0);
    run_op("multu_max",  OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MUL_LAT, 0);
    run_op("mult_mixed", OP_MULT,  32'h5,        32'hFFFFFFFC, 32'hFFFFFFFF, 32'hFFFFFFEC, MUL_LAT, 0);
    run_op("multu_wide", OP_MULTU, 32'h12345678, 32'h10,       32'h00000001, 32'h23456780, MUL_LAT, 0);
    run_op("div_neg",    OP_DIV,   32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD, W, 0);
    run_op("div_min",    OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, W, 0);
    run_op("div_negdiv", OP_DIV,   32'h7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, W, 0);
    run_op("divu_zero",  OP_DIVU,  32'h7,        32'h0,        32'h00000007, 32'hFFFFFFFF, W, 0);
    @(negedge clk);
    check("done_once", done, 0);
    run_op("div_zero_neg", OP_DIV, 32'hFFFFFFF9, 32'h0,        32'hFFFFFFF9, 32'hFFFFFFFF, W, 0);

    // MTHI / MTLO, the first issued in the done cycle
    op = OP_MTHI; src1 = 32'h1234; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("mthi_hi", hi, 32'h1234);
    check("mthi_busy", busy, 0);
    check("mthi_done", done, 0);
    op = OP_MTLO; src1 = 32'hABCD; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("mtlo_lo", lo, 32'hABCD);
    check("mtlo_hi", hi, 32'h1234);

    // cancel mid-run
    op = OP_DIVU; src1 = 32'd100; src2 = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check("cancel_busy", busy, 0);
    check("cancel_hi", hi, 32'h1234);
    check("cancel_lo", lo, 32'hABCD);
    saw = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) saw = 1'b1;
    end
    check("cancel_no_done", saw, 0);

    // cancel together with start in idle drops the request
    op = OP_MULTU; src1 = 32'd3; src2 = 32'd5; start = 1'b1; cancel = 1'b1;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    check("cancel_idle_busy", busy, 0);

    run_op("divu_restart", OP_DIVU, 32'd100,  32'd7,  32'd2, 32'd14,  W, 0);
    run_op("busy_ignore",  OP_DIVU, 32'd1000, 32'd10, 32'd0, 32'd100, W, 5);

    // reset mid-operation
    @(negedge clk);
    op = OP_DIVU; src1 = 32'd100; src2 = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_hi", hi, 0);
    check("midrst_lo", lo, 0);
    saw = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) saw = 1'b1;
    end
    check("midrst_no_done", saw, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
